// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, delayed-branch redirect, IF/ID pipeline
// register with misaligned-fetch flagging, and a saturating stall counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_sel,
    input  logic [31:0] npc,
    input  logic        annul,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        adel_d,
    output logic [31:0] stall_cnt
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] CNT_MAX = {XLEN{1'b1}};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] instr_nxt;
    logic [XLEN-1:0] pc8_nxt;
    logic            valid_nxt;
    logic            adel_nxt;
    logic [XLEN-1:0] stall_cnt_nxt;
    logic            misaligned;

    // PC feeds instruction memory straight from the register, so no
    // control input has a combinational path to pc_out.
    assign pc_out     = pc_q;
    assign misaligned = (pc_q[1:0] != 2'b00);

    // Next-state for PC, IF/ID and the stall counter.
    always_comb begin
        pc_nxt        = pc_q;
        instr_nxt     = instr_d;
        pc8_nxt       = pc8_d;
        valid_nxt     = valid_d;
        adel_nxt      = adel_d;
        stall_cnt_nxt = stall_cnt;

        if (stall) begin
            stall_cnt_nxt = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + XLEN'(1);
        end else begin
            // Delay slot enters IF/ID on the same edge PC takes the target.
            pc_nxt  = jump_sel ? npc : pc_q + XLEN'(4);
            pc8_nxt = pc_q + XLEN'(8);
            if (annul) begin
                instr_nxt = '0;
                valid_nxt = 1'b0;
                adel_nxt  = 1'b0;
            end else begin
                instr_nxt = misaligned ? '0 : instr_in;
                valid_nxt = 1'b1;
                adel_nxt  = misaligned;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            instr_d   <= '0;
            pc8_d     <= '0;
            valid_d   <= 1'b0;
            adel_d    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pc_q      <= pc_nxt;
            instr_d   <= instr_nxt;
            pc8_d     <= pc8_nxt;
            valid_d   <= valid_nxt;
            adel_d    <= adel_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

endmodule
